timer_dev: RTL and testbench

Memory-mapped countdown timer on the CPU's external data bus: the responder that the core's timer-window loads/stores (0x7F00–0x7F0B, 0x7F10–0x7F1B) reach through the bridge. Two instances sit behind the bridge, one per window. Each holds CTRL/PRESET/COUNT, runs a four-state countdown FSM and drives one bit of the CPU's HWInt vector. The CPU already rejects sub-word and COUNT stores to this window, so this block only sees full-word accesses.

---
 rtl/timer_dev_pkg.sv | 26 ++
 rtl/timer_dev.sv | 91 +++++++++
 tb/tb_timer_dev.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared definitions for the memory-mapped countdown timer.
//   - FSM state encoding (TIMER_IDLE/LOAD/CNT/INT)
//   - register word offsets (addr[3:2] of the bus address)
//   - CTRL bit positions and MODE values
package timer_dev_pkg;

  typedef enum logic [1:0] {
    TIMER_IDLE = 2'd0,
    TIMER_LOAD = 2'd1,
    TIMER_CNT  = 2'd2,
    TIMER_INT  = 2'd3
  } timer_state_e;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Only MODE=1 reloads; 0, 2 and 3 all behave as one-shot.
  localparam logic [1:0] MODE_RELOAD = 2'd1;

endpackage

// File: rtl/timer_dev.sv
// timer_dev: countdown timer responder behind the CPU bus bridge.
// Holds CTRL[3:0] (EN, MODE, IM), PRESET and COUNT; a four-state FSM
// loads PRESET, counts down to zero, raises a sticky flag and either
// disables itself (one-shot) or re-arms (auto-reload).
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   sel    in   chip-select for this instance's window
//   we     in   write strobe, qualified by sel
//   addr   in   [1:0] word offset: 0 CTRL, 1 PRESET, 2 COUNT, 3 unused
//   wdata  in   [31:0] write data
//   rdata  out  [31:0] combinational read data for addr (ignores sel)
//   irq    out  flag & IM
module timer_dev
  import timer_dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  timer_state_e state;
  logic [3:0]   ctrl;
  logic [31:0]  preset;
  logic [31:0]  count;
  logic         flag;

  logic reg_wr;
  assign reg_wr = sel && we && (addr == TIMER_CTRL || addr == TIMER_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= TIMER_IDLE;
      ctrl   <= 4'd0;
      preset <= 32'd0;
      count  <= 32'd0;
      flag   <= 1'b0;
    end else if (reg_wr) begin
      // A register write takes precedence over every FSM update this edge
      // and parks the FSM in IDLE with the flag cleared.
      if (addr == TIMER_CTRL) ctrl   <= wdata[3:0];
      else                    preset <= wdata;
      state <= TIMER_IDLE;
      flag  <= 1'b0;
    end else begin
      case (state)
        TIMER_IDLE: if (ctrl[CTRL_EN]) state <= TIMER_LOAD;
        TIMER_LOAD: begin
          count <= preset;
          state <= TIMER_CNT;
        end
        TIMER_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= TIMER_IDLE;              // COUNT freezes
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // Covers COUNT of 1 and 0, so PRESET=0 acts like PRESET=1.
            count <= 32'd0;
            flag  <= 1'b1;
            state <= TIMER_INT;
          end
        end
        TIMER_INT: begin
          if (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) flag <= 1'b0;
          else                                                ctrl[CTRL_EN] <= 1'b0;
          state <= TIMER_IDLE;
        end
        default: state <= TIMER_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      TIMER_CTRL:   rdata = {28'd0, ctrl};
      TIMER_PRESET: rdata = preset;
      TIMER_COUNT:  rdata = count;
      default:      rdata = 32'd0;
    endcase
  end

  assign irq = flag & ctrl[CTRL_IM];

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed scenarios plus randomized bus traffic, checked
// every cycle against a schedule-based reference model of the timer.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        reset, sel, we;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  timer_dev dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we),
    .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: a run is a schedule measured in edges since the
  // edge that entered the load step (el). el=1 loads PRESET, the count
  // then falls one per edge to 0 at el=P'+1 (P'=max(PRESET,1)) where
  // the flag sets, and at el=P'+2 the run ends.
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre, m_cnt;
  logic        m_flag;
  bit          m_run;
  int          m_start, edge_n;

  function automatic void model_edge(bit r, bit s, bit w, logic [1:0] a, logic [31:0] d);
    int el, pe;
    edge_n++;
    if (r) begin
      m_ctrl = 0; m_pre = 0; m_cnt = 0; m_flag = 0; m_run = 0;
      return;
    end
    if (s && w && a < 2'd2) begin
      if (a == 2'd0) m_ctrl = d[3:0];
      else           m_pre  = d;
      m_run = 0; m_flag = 0;
      return;
    end
    if (!m_run) begin
      if (m_ctrl[0]) begin m_run = 1; m_start = edge_n; end
      return;
    end
    el = edge_n - m_start;
    pe = (m_pre == 0) ? 1 : int'(m_pre);
    if (el == 1) begin
      m_cnt = m_pre;
    end else if (el <= pe + 1) begin
      if (!m_ctrl[0]) m_run = 0;
      else begin
        m_cnt = 32'(pe - (el - 1));
        if (el == pe + 1) m_flag = 1;
      end
    end else begin
      m_run = 0;
      if (m_ctrl[2:1] == 2'd1) m_flag = 0;
      else                     m_ctrl[0] = 0;
    end
  endfunction

  function automatic logic [31:0] exp_rd(int a);
    case (a)
      0: return {28'd0, m_ctrl};
      1: return m_pre;
      2: return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a; #1; v = rdata;
  endtask

  // One clock: drive inputs, take the edge, advance the model, then read
  // back every offset and irq against the model.
  task automatic step(input bit r, input bit s, input bit w, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    reset = r; sel = s; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(r, s, w, a, d);
    #1; reset = 0; sel = 0; we = 0;
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      chk($sformatf("rd%0d", i), v, exp_rd(i));
    end
    chk("irq", {31'd0, irq}, {31'd0, m_flag & m_ctrl[3]});
  endtask

  task automatic idle(); step(0, 0, 0, 2'(($urandom % 4)), $urandom); endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d); step(0, 1, 1, a, d); endtask

  initial begin
    logic [31:0] v;
    int pulses[$];
    int n;
    bit ok;
    reset = 1; sel = 0; we = 0; addr = 0; wdata = 0; edge_n = 0;
    m_ctrl = 0; m_pre = 0; m_cnt = 0; m_flag = 0; m_run = 0; m_start = 0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 32'hF);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(0, v); chk("rst_ctrl", v, 0);

    // One-shot with interrupt: COUNT 5..0 on edges 2..7
    wr(1, 5);
    wr(0, 32'h9);                 // edge 0
    idle();                       // edge 1 (load)
    for (int k = 2; k <= 7; k++) begin
      idle();
      rd(2, v); chk("os_cnt", v, 32'(7 - k));
    end
    chk("os_irq_hi", {31'd0, irq}, 32'd1);
    idle();                       // edge 8
    rd(0, v); chk("os_en_off", v & 32'h1, 0);
    chk("os_irq_hold", {31'd0, irq}, 32'd1);
    idle(); idle();
    chk("os_irq_sticky", {31'd0, irq}, 32'd1);
    wr(1, 5);
    chk("os_irq_drop", {31'd0, irq}, 32'd0);

    // Auto-reload: one-cycle pulses every 6 cycles
    wr(1, 3);
    wr(0, 32'hB);
    for (int k = 0; k < 26; k++) begin
      idle();
      if (irq) pulses.push_back(edge_n);
    end
    chk("ar_npulse_ge3", {31'd0, pulses.size() >= 3}, 32'd1);
    for (int k = 1; k < pulses.size(); k++)
      chk("ar_period", 32'(pulses[k] - pulses[k-1]), 32'd6);

    // One-shot, IM=0: flag sets silently; CTRL=0x8 clears it
    wr(1, 3);
    wr(0, 32'h1);
    for (int k = 0; k < 8; k++) idle();
    chk("noim_irq", {31'd0, irq}, 32'd0);
    wr(0, 32'h8);
    chk("noim_after", {31'd0, irq}, 32'd0);

    // Mid-count disable at COUNT=7, ignored writes, re-enable reloads
    wr(1, 10);
    wr(0, 32'h1);
    n = 0; ok = 0;
    while (n < 20 && !ok) begin
      idle(); n++;
      rd(2, v); ok = (v == 32'd7);
    end
    chk("mid_reach7", {31'd0, ok}, 32'd1);
    wr(0, 32'h0);
    idle(); idle();
    rd(2, v); chk("mid_frozen", v, 7);
    step(0, 0, 1, 1, 32'd99);     // sel=0
    rd(1, v); chk("nosel_pre", v, 10);
    wr(2, 32'd1234);              // COUNT is read-only
    rd(2, v); chk("off2_cnt", v, 7);
    wr(0, 32'h1);
    idle();
    idle();
    rd(2, v); chk("reload_cnt", v, 10);

    // Reset while interrupting
    wr(1, 2);
    wr(0, 32'h9);
    n = 0;
    while (n < 10 && !irq) begin idle(); n++; end
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    step(1, 1, 1, 0, 32'hF);
    chk("rst_int_irq", {31'd0, irq}, 32'd0);
    rd(1, v); chk("rst_int_pre", v, 0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [1:0] a;
      a = 2'($urandom % 4);
      step(($urandom_range(0, 199) == 0), ($urandom % 4 != 0), ($urandom % 6 == 0), a,
           (a == 2'd1) ? 32'($urandom_range(0, 8)) : $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
